// File: rtl/seq_signed_mult_n.sv
// Sequential signed multiplier: sign-magnitude shift-and-add over WIDTH cycles.
// Define MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module seq_signed_mult_n #(
    parameter int WIDTH = 8
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic                 zflag,
    output logic [2*WIDTH-2:0]   product_mag,
    output logic                 sign,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] scan;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc;
    logic             pend_sign;

    logic [PW-1:0]    acc_sum;
    logic             last_edge;
    logic             res_sign;
    logic [PW:0]      res_prod;

`ifndef MULT_EARLY_EXIT_EN
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    logic [CNT_W-1:0] cnt;
`endif

    // Magnitude as an unsigned WIDTH-bit value; the most negative operand maps
    // to 2^(WIDTH-1), which still fits because the result is read as unsigned.
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    assign zflag = (scan == '0);

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        acc_sum   = acc + (scan[0] ? addend : '0);
        res_sign  = pend_sign & (acc_sum != '0);
        res_prod  = res_sign ? (~{1'b0, acc_sum} + (PW + 1)'(1)) : {1'b0, acc_sum};
`ifdef MULT_EARLY_EXIT_EN
        last_edge = ((scan >> 1) == '0);
`else
        last_edge = (cnt == CNT_LAST);
`endif
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            scan        <= '0;
            addend      <= '0;
            acc         <= '0;
            pend_sign   <= 1'b0;
            product_mag <= '0;
            sign        <= 1'b0;
            product     <= '0;
`ifndef MULT_EARLY_EXIT_EN
            cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        scan      <= mag_of(multiplier);
                        addend    <= PW'(mag_of(multiplicand));
                        acc       <= '0;
                        pend_sign <= multiplier[WIDTH-1] ^ multiplicand[WIDTH-1];
`ifndef MULT_EARLY_EXIT_EN
                        cnt       <= '0;
`endif
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                RUN: begin
                    acc    <= acc_sum;
                    addend <= addend << 1;
                    scan   <= scan >> 1;
`ifndef MULT_EARLY_EXIT_EN
                    cnt    <= cnt + 1'b1;
`endif
                    // Results are only published on the final edge so they hold steady during RUN.
                    if (last_edge) begin
                        product_mag <= acc_sum;
                        sign        <= res_sign;
                        product     <= res_prod;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_mult_n.sv
// Self-checking bench for seq_signed_mult_n: vector table, hand-written corner
// sequences and randomized operands against an arithmetic reference model.
module tb_seq_signed_mult_n;

    localparam int W  = 8;
    localparam int W2 = 16;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic              rst_n;
    logic              start;
    logic [W-1:0]      multiplier, multiplicand;
    logic              busy, done, zflag, sign;
    logic [2*W-2:0]    product_mag;
    logic [2*W-1:0]    product;

    logic              start16;
    logic [W2-1:0]     multiplier16, multiplicand16;
    logic              busy16, done16, zflag16, sign16;
    logic [2*W2-2:0]   product_mag16;
    logic [2*W2-1:0]   product16;

    seq_signed_mult_n #(.WIDTH(W)) u_dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start),
        .multiplier(multiplier), .multiplicand(multiplicand),
        .busy(busy), .done(done), .zflag(zflag),
        .product_mag(product_mag), .sign(sign), .product(product)
    );

    seq_signed_mult_n #(.WIDTH(W2)) u_dut16 (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start16),
        .multiplier(multiplier16), .multiplicand(multiplicand16),
        .busy(busy16), .done(done16), .zflag(zflag16),
        .product_mag(product_mag16), .sign(sign16), .product(product16)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*W-1:0] last_prod;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-2:0] mag;
        logic           sg;
        logic [2*W-1:0] prod;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected edges from capture to DONE for a given multiplier.
    function automatic int exp_lat(input logic [63:0] a, input int width);
`ifdef MULT_EARLY_EXIT_EN
        longint m;
        int k;
        m = a[width-1] ? ((64'd1 << width) - longint'(a)) : longint'(a);
        k = 0;
        while (m > 0) begin
            k++;
            m = m >> 1;
        end
        return (k < 1) ? 1 : k;
`else
        return (a[0] === 1'bx) ? 0 : width;
`endif
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-2:0] emag, input logic esg,
                          input logic [2*W-1:0] eprod, input int inject_at,
                          input string tag);
        int lat;
        bit seen;
        @(negedge sys_clk);
        start = 1'b1; multiplier = a; multiplicand = b;
        @(posedge sys_clk); #1;
        check({tag, "_busy_at_capture"}, 64'(busy), 64'd1);
        start = 1'b0; multiplier = W'($urandom); multiplicand = W'($urandom);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 2 * W + 4) begin
            @(posedge sys_clk); #1;
            lat++;
            if (inject_at > 0 && lat == inject_at - 1) begin
                start = 1'b1; multiplier = 8'h09; multiplicand = 8'h09;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                check({tag, "_busy_in_run"}, 64'(busy), 64'd1);
                check({tag, "_product_held"}, 64'(product), 64'(last_prod));
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_latency"}, 64'(lat), 64'(exp_lat(64'(a), W)));
            check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
            check({tag, "_mag"}, 64'(product_mag), 64'(emag));
            check({tag, "_sign"}, 64'(sign), 64'(esg));
            check({tag, "_product"}, 64'(product), 64'(eprod));
        end
        last_prod = eprod;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, m, done_cnt, lat;
        bit seen;
        logic [W-1:0] ra, rb;

        vecs[0] = '{8'h05, 8'hFD, 15'd15,    1'b1, 16'hFFF1};
        vecs[1] = '{8'h80, 8'h80, 15'd16384, 1'b0, 16'h4000};
        vecs[2] = '{8'h7F, 8'h7F, 15'd16129, 1'b0, 16'h3F01};
        vecs[3] = '{8'h80, 8'h7F, 15'd16256, 1'b1, 16'hC080};
        vecs[4] = '{8'hFF, 8'h01, 15'd1,     1'b1, 16'hFFFF};
        vecs[5] = '{8'hFD, 8'h00, 15'd0,     1'b0, 16'h0000};
        vecs[6] = '{8'hFB, 8'hFA, 15'd30,    1'b0, 16'h001E};
        vecs[7] = '{8'h05, 8'h03, 15'd15,    1'b0, 16'h000F};

        rst_n = 1'b0; start = 1'b0; multiplier = '0; multiplicand = '0;
        start16 = 1'b0; multiplier16 = '0; multiplicand16 = '0;
        last_prod = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_mag", 64'(product_mag), 64'd0);
        check("reset_sign", 64'(sign), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        check("reset_zflag", 64'(zflag), 64'd1);
        @(negedge sys_clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].mag, vecs[i].sg, vecs[i].prod, 0,
                   $sformatf("vec%0d", i));
        end

        // Zero multiplier, then one idle cycle to confirm IDLE with zflag set.
        run_op(8'h00, 8'hF9, 15'd0, 1'b0, 16'h0000, 0, "zero_mult");
        @(posedge sys_clk); #1;
        check("zero_idle_busy", 64'(busy), 64'd0);
        check("zero_idle_done", 64'(done), 64'd0);
        check("zero_idle_zflag", 64'(zflag), 64'd1);

        // Start pulse sampled at RUN edge t+3 must not disturb the operation.
        run_op(8'h80, 8'h03, 15'd384, 1'b1, 16'hFE80, 3, "ignore_start");
        @(posedge sys_clk); #1;
        check("ignore_start_idle_busy", 64'(busy), 64'd0);
        check("ignore_start_idle_product", 64'(product), 64'hFE80);

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            p  = int'($signed(ra)) * int'($signed(rb));
            m  = (p < 0) ? -p : p;
            run_op(ra, rb, m[2*W-2:0], (p < 0), p[2*W-1:0], 0, $sformatf("rnd%0d", i));
            if (($urandom % 3) == 0) repeat ($urandom_range(1, 3)) @(posedge sys_clk);
        end

        // Force a known non-zero held result, then reset mid-RUN.
        run_op(8'h07, 8'h06, 15'd42, 1'b0, 16'h002A, 0, "pre_reset");
        @(negedge sys_clk);
        start = 1'b1; multiplier = 8'h80; multiplicand = 8'h05;
        @(posedge sys_clk); #1;
        start = 1'b0;
        repeat (3) @(posedge sys_clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_done", 64'(done), 64'd0);
        check("midrun_reset_mag", 64'(product_mag), 64'd0);
        check("midrun_reset_sign", 64'(sign), 64'd0);
        check("midrun_reset_product", 64'(product), 64'd0);
        check("midrun_reset_zflag", 64'(zflag), 64'd1);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge sys_clk); #1;
            if (done) done_cnt++;
        end
        check("midrun_reset_no_done", 64'(done_cnt), 64'd0);
        last_prod = '0;
        run_op(8'h05, 8'hFD, 15'd15, 1'b1, 16'hFFF1, 0, "post_reset");

        // WIDTH=16 corner: 32767 x -32768.
        @(negedge sys_clk);
        start16 = 1'b1; multiplier16 = 16'h7FFF; multiplicand16 = 16'h8000;
        @(posedge sys_clk); #1;
        check("w16_busy_at_capture", 64'(busy16), 64'd1);
        start16 = 1'b0; multiplier16 = '0; multiplicand16 = '0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 2 * W2 + 4) begin
            @(posedge sys_clk); #1;
            lat++;
            if (done16) seen = 1'b1;
        end
        check("w16_done_seen", 64'(seen), 64'd1);
        check("w16_latency", 64'(lat), 64'(exp_lat(64'h7FFF, W2)));
        check("w16_mag", 64'(product_mag16), 64'd1073709056);
        check("w16_sign", 64'(sign16), 64'd1);
        check("w16_product", 64'(product16), 64'hC0008000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
